// File: rtl/pool2x2_relu_if.sv
// Row-stream interface for pool2x2_relu: input row handshake, pooled output row
// handshake and the sticky odd_rows status flag.
interface pool2x2_relu_if #(
    parameter int LANES  = 16,
    parameter int DW     = 16,
    parameter int RCNT_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*DW-1:0]      in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [(LANES/2)*DW-1:0]  out_data;
    logic                     out_last;
    logic [RCNT_W-1:0]        out_row_idx;
    logic                     odd_rows;

    // Producer/consumer side (drives input rows, accepts pooled rows)
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_row_idx, odd_rows
    );

    // Pooling stage side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_row_idx, odd_rows
    );
endinterface

// File: rtl/pool2x2_relu.sv
// 2x2 max-pool of 16-lane conv rows into 8-lane pooled rows, one row pair per output.
// Optional ReLU on the pooled value is enabled by defining POOL_RELU_EN.
module pool2x2_relu #(
    parameter int LANES  = 16,
    parameter int DW     = 16,
    parameter int RCNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    pool2x2_relu_if.slave bus
);
    localparam int OL = LANES / 2;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    logic signed [DW-1:0]    h        [OL];
    logic signed [DW-1:0]    buf_reg  [OL];
    logic [OL*DW-1:0]        pooled_data;

    logic                    out_valid_reg;
    logic                    out_last_reg;
    logic [OL*DW-1:0]        out_data_reg;
    logic [RCNT_W-1:0]       row_idx_reg;
    logic                    odd_rows_reg;

    logic                    out_free;
    logic                    in_ready;
    logic                    accept;
    logic                    load;
    logic                    store;
    logic                    odd_set;

    // Per output lane: horizontal pair max, vertical max against the held row, optional clamp
    generate
        for (genvar gi = 0; gi < OL; gi++) begin : g_lane
            logic signed [DW-1:0] even_px;
            logic signed [DW-1:0] odd_px;
            logic signed [DW-1:0] pair_max;

            assign even_px  = bus.in_data[(2*gi)*DW +: DW];
            assign odd_px   = bus.in_data[(2*gi+1)*DW +: DW];
            assign h[gi]    = (odd_px > even_px) ? odd_px : even_px;
            assign pair_max = (state_reg == ODD && buf_reg[gi] > h[gi]) ? buf_reg[gi] : h[gi];
`ifdef POOL_RELU_EN
            assign pooled_data[gi*DW +: DW] = pair_max[DW-1] ? '0 : pair_max;
`else
            assign pooled_data[gi*DW +: DW] = pair_max;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EVEN;
        end else begin
            state_reg <= state_next;
        end
    end

    // A last row arriving in EVEN produces output immediately, so it must wait for a free slot
    always_comb begin
        out_free   = !out_valid_reg || bus.out_ready;
        state_next = state_reg;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        store      = 1'b0;
        odd_set    = 1'b0;
        case (state_reg)
            EVEN: begin
                in_ready = !bus.in_last || out_free;
                accept   = bus.in_valid && in_ready;
                if (accept) begin
                    if (bus.in_last) begin
                        load    = 1'b1;
                        odd_set = 1'b1;
                    end else begin
                        store      = 1'b1;
                        state_next = ODD;
                    end
                end
            end
            ODD: begin
                in_ready = out_free;
                accept   = bus.in_valid && in_ready;
                if (accept) begin
                    load       = 1'b1;
                    state_next = EVEN;
                end
            end
            default: begin
                state_next = EVEN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < OL; j++) begin
                buf_reg[j] <= '0;
            end
        end else if (store) begin
            for (int j = 0; j < OL; j++) begin
                buf_reg[j] <= h[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= pooled_data;
            out_last_reg  <= bus.in_last;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Index advances on each drained row; a drained map-closing row restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx_reg <= '0;
        end else if (out_valid_reg && bus.out_ready) begin
            row_idx_reg <= out_last_reg ? '0 : row_idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd_rows_reg <= 1'b0;
        end else if (odd_set) begin
            odd_rows_reg <= 1'b1;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.out_last    = out_last_reg;
    assign bus.out_row_idx = row_idx_reg;
    assign bus.odd_rows    = odd_rows_reg;
endmodule

// File: tb/tb_pool2x2_relu.sv
// Directed bench for pool2x2_relu: a row-pairing reference model checked every cycle,
// plus literal expectations for the individual scenarios.
module tb_pool2x2_relu;
    localparam int LANES  = 16;
    localparam int DW     = 16;
    localparam int RCNT_W = 8;
    localparam int OL     = LANES / 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pool2x2_relu_if #(.LANES(LANES), .DW(DW), .RCNT_W(RCNT_W)) bus ();

    pool2x2_relu #(.LANES(LANES), .DW(DW), .RCNT_W(RCNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane_of(input logic [LANES*DW-1:0] v, input int k);
        logic signed [DW-1:0] t;
        t = v[k*DW +: DW];
        return int'(t);
    endfunction

    function automatic int out_lane(input int j);
        logic signed [DW-1:0] t;
        t = bus.out_data[j*DW +: DW];
        return int'(t);
    endfunction

    function automatic int fm(input int x);
`ifdef POOL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [LANES*DW-1:0] mk_row(input int base, input int step);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*DW +: DW] = DW'(base + step * k);
        return r;
    endfunction

    function automatic logic [LANES*DW-1:0] mk_pair(input int ev, input int od);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*DW +: DW] = DW'((k % 2 == 0) ? ev : od);
        return r;
    endfunction

    // Reference model: what the stage holds/shows, advanced once per clock at the negedge
    bit pend_m, ov_m, last_m, odd_m;
    int buf_m [OL];
    int data_m [OL];
    int cnt_m;
    int out_xfers = 0;

    always @(negedge clk) begin
        bit out_free, inr, acc, drain;
        int hv [OL];
        if (!rst_n) begin
            pend_m = 0; ov_m = 0; last_m = 0; odd_m = 0; cnt_m = 0;
            for (int j = 0; j < OL; j++) begin buf_m[j] = 0; data_m[j] = 0; end
        end
        out_free = !ov_m || bus.out_ready;
        inr      = pend_m ? out_free : (!bus.in_last || out_free);
        check("in_ready", bus.in_ready, inr);
        check("out_valid", bus.out_valid, ov_m);
        check("odd_rows", bus.odd_rows, odd_m);
        if (ov_m) begin
            for (int j = 0; j < OL; j++) check($sformatf("out_lane%0d", j), out_lane(j), data_m[j]);
            check("out_last", bus.out_last, last_m);
            check("out_row_idx", bus.out_row_idx, cnt_m % (1 << RCNT_W));
        end
        if (rst_n) begin
            acc   = bus.in_valid && inr;
            drain = ov_m && bus.out_ready;
            for (int j = 0; j < OL; j++) begin
                int a, b;
                a = lane_of(bus.in_data, 2*j);
                b = lane_of(bus.in_data, 2*j+1);
                hv[j] = (a > b) ? a : b;
            end
            if (acc) $display("IN  last=%0d lane0=%0d lane1=%0d", bus.in_last, lane_of(bus.in_data, 0), lane_of(bus.in_data, 1));
            if (drain) begin
                $display("OUT idx=%0d last=%0d lane0=%0d lane7=%0d", bus.out_row_idx, bus.out_last, out_lane(0), out_lane(7));
                out_xfers++;
                cnt_m = last_m ? 0 : cnt_m + 1;
            end
            if (acc && (pend_m || bus.in_last)) begin
                for (int j = 0; j < OL; j++) data_m[j] = fm(pend_m ? ((buf_m[j] > hv[j]) ? buf_m[j] : hv[j]) : hv[j]);
                if (!pend_m) odd_m = 1;
                last_m = bus.in_last;
                ov_m   = 1;
                pend_m = 0;
            end else begin
                if (acc) begin
                    for (int j = 0; j < OL; j++) buf_m[j] = hv[j];
                    pend_m = 1;
                end
                if (drain) ov_m = 0;
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int k = 0; k < LANES * DW / 32; k++) bus.in_data[k*32 +: 32] = $urandom();
    endtask

    task automatic send_row(input logic [LANES*DW-1:0] d, input logic l, output int waited);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        waited = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited >= 100) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        int w, wsum, x0;
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w, wsum, x0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data_zero", (bus.out_data == '0) ? 1 : 0, 1);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_row_idx", bus.out_row_idx, 0);
        check("rst_odd_rows", bus.odd_rows, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: lanes k then -k -> lane j = 2j+1, visible 1 clk after second accept
        send_row(mk_row(0, 1), 1'b0, w);
        check("t1_no_out_after_r0", bus.out_valid, 0);
        send_row(mk_row(0, -1), 1'b1, w);
        check("t1_out_valid", bus.out_valid, 1);
        for (int j = 0; j < OL; j++) check($sformatf("t1_lane%0d", j), out_lane(j), 2*j + 1);
        check("t1_idx", bus.out_row_idx, 0);
        @(posedge clk); #1;

        // 2: all-negative pair -> -1, or 0 with ReLU
        send_row(mk_pair(-5, -3), 1'b0, w);
        send_row(mk_pair(-7, -1), 1'b1, w);
`ifdef POOL_RELU_EN
        check("t2_lane0", out_lane(0), 0);
        check("t2_lane7", out_lane(7), 0);
`else
        check("t2_lane0", out_lane(0), -1);
        check("t2_lane7", out_lane(7), -1);
`endif
        @(posedge clk); #1;

        // 3: 4-row map with a stalled consumer
        bus.out_ready = 1'b0;
        send_row(mk_row(100, 1), 1'b0, w);
        send_row(mk_row(50, 1), 1'b0, w);
        check("t3_first_lane0", out_lane(0), 101);
        check("t3_first_idx", bus.out_row_idx, 0);
        send_row(mk_row(0, 3), 1'b0, w);
        check("t3_r2_no_wait", w, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = mk_row(200, -1);
        bus.in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t3_stall_in_ready", bus.in_ready, 0);
            check("t3_hold_lane0", out_lane(0), 101);
            check("t3_hold_idx", bus.out_row_idx, 0);
            check("t3_hold_last", bus.out_last, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        idle_inputs();
        check("t3_second_lane0", out_lane(0), 200);
        check("t3_second_idx", bus.out_row_idx, 1);
        check("t3_second_last", bus.out_last, 1);
        @(posedge clk); #1;
        check("t3_idx_restart", bus.out_row_idx, 0);

        // 4: 3-row map, last row is unpaired
        check("t4_odd_before", bus.odd_rows, 0);
        send_row(mk_row(1, 1), 1'b0, w);
        send_row(mk_row(2, 1), 1'b0, w);
        check("t4_first_lane0", out_lane(0), 3);
        check("t4_first_idx", bus.out_row_idx, 0);
        send_row(mk_row(0, 10), 1'b1, w);
        check("t4_single_lane3", out_lane(3), 70);
        check("t4_single_last", bus.out_last, 1);
        check("t4_single_idx", bus.out_row_idx, 1);
        check("t4_odd_rows", bus.odd_rows, 1);

        // 5: back-to-back rows at full rate
        wsum = 0;
        x0 = out_xfers;
        for (int i = 0; i < 6; i++) begin
            send_row(mk_row(i * 10, 1), (i == 5) ? 1'b1 : 1'b0, w);
            wsum += w;
        end
        repeat (2) @(posedge clk); #1;
        check("t5_no_stall", wsum, 0);
        check("t5_out_rows", out_xfers - x0, 4);
        check("t5_odd_sticky", bus.odd_rows, 1);

        // 6: reset with a row held -> held row discarded, pairing restarts
        send_row(mk_row(1000, 1), 1'b0, w);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t6_odd_cleared", bus.odd_rows, 0);
        send_row(mk_row(1, 1), 1'b0, w);
        check("t6_no_out_after_a", bus.out_valid, 0);
        send_row(mk_row(5, -1), 1'b1, w);
        check("t6_lane0", out_lane(0), 5);
        check("t6_lane1", out_lane(1), 4);
        check("t6_idx", bus.out_row_idx, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
